uart_tx_fifo: RTL and testbench

- UART 8N1 transmitter with a small byte FIFO. It is the return-path counterpart of the panel's UART receiver.
- Lets panel logic report status, echo bytes or acknowledge frames back to the host over the icebreaker FTDI link.
- Sits in the CLK domain beside the led_panel_single core; its serial output drives a top-level pin.

---
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : 8N1 UART transmitter fed by a small circular byte FIFO.
//               Frames are sent back-to-back while bytes remain queued.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic [7:0]          tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_out,
  output logic                busy,
  output logic [DEPTH_LOG2:0] fifo_level
);

  localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
  localparam int                  c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0]  c_BAUD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] c_FULL      = (DEPTH_LOG2 + 1)'(c_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                state_q;
  logic [c_CNT_W-1:0]    baud_q;
  logic [2:0]            bit_q;
  logic [7:0]            shift_q;
  logic                  tx_q;

  logic [7:0]            mem_q [c_DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_d;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_baud_end;
  logic                  w_not_empty;

  assign w_not_empty = (level_q != '0);
  assign tx_ready    = (level_q != c_FULL);
  assign w_push      = tx_valid && tx_ready;
  assign w_baud_end  = (baud_q == c_BAUD_LAST);
  // The FSM loads a byte either from idle or straight out of a finishing stop bit.
  assign w_pop       = w_not_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && w_baud_end));

  always_comb begin
    level_d = level_q;
    if (w_push && !w_pop) begin
      level_d = level_q + 1'b1;
    end else if (!w_push && w_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      mem_q[wptr_q] <= tx_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (w_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (w_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      level_q <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (w_pop) begin
            shift_q <= mem_q[rptr_q];
            baud_q  <= '0;
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            baud_q <= '0;
            if (w_pop) begin
              shift_q <= mem_q[rptr_q];
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_out     = tx_q;
  assign busy       = (state_q != S_IDLE) || w_not_empty;
  assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Scoreboard bench for uart_tx_fifo with a line-level reference
//               model and a reference UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int N  = 4;
  localparam int N2 = 104;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;
  logic [2:0] fifo_level;

  logic [7:0] d2_data = 8'h00;
  logic       d2_valid = 1'b0;
  logic       d2_ready;
  logic       d2_out;
  logic       d2_busy;
  logic [2:0] d2_level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  uart_tx_fifo #(.CLKS_PER_BIT(N), .DEPTH_LOG2(2)) u_dut (
    .CLK(CLK), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_fifo u_dut104 (
    .CLK(CLK), .rst(rst), .tx_data(d2_data), .tx_valid(d2_valid),
    .tx_ready(d2_ready), .tx_out(d2_out), .busy(d2_busy), .fifo_level(d2_level)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference model: a pending-byte queue and the start edge of the current frame.
  int         edge_n    = 0;
  int         frame_end = 0;
  int         cur_start = 0;
  logic [7:0] cur_byte  = 8'h00;
  int         reset_gen = 0;
  bit         model_ok  = 1'b0;
  logic [7:0] mq[$];
  logic [7:0] sbq[$];

  always @(posedge CLK) begin : model
    int sz;
    bit acc;
    bit st;
    edge_n++;
    if (rst) begin
      mq.delete();
      sbq.delete();
      frame_end = edge_n;
      reset_gen++;
    end else begin
      sz  = mq.size();
      acc = tx_valid && (sz < 4);
      st  = (sz > 0) && (edge_n >= frame_end);
      if (st) begin
        cur_byte  = mq.pop_front();
        cur_start = edge_n;
        frame_end = edge_n + 10 * N;
      end
      if (acc) begin
        mq.push_back(tx_data);
        sbq.push_back(tx_data);
      end
    end
    model_ok = 1'b1;
  end

  function automatic bit exp_line();
    int off;
    int b;
    if (edge_n >= frame_end) return 1'b1;
    off = edge_n - cur_start;
    b   = off / N;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur_byte[b-1];
    return 1'b1;
  endfunction

  always @(negedge CLK) begin : cycle_checker
    if (model_ok) begin
      check("tx_out", tx_out, exp_line());
      check("fifo_level", fifo_level, mq.size());
      check("tx_ready", tx_ready, (mq.size() < 4) ? 1 : 0);
      check("busy", busy, ((edge_n < frame_end) || (mq.size() > 0)) ? 1 : 0);
    end
  end

  // Reference receiver: captures whole frames and pops the expected byte.
  int         dec_gen  = 0;
  bit         in_frame = 1'b0;
  int         k        = 0;
  logic       samp[10*N];
  bit         shape_ok;
  logic [7:0] dec_byte;

  always @(negedge CLK) begin : monitor
    if (dec_gen != reset_gen) begin
      in_frame = 1'b0;
      dec_gen  = reset_gen;
    end
    if (model_ok && !in_frame && tx_out == 1'b0) begin
      in_frame = 1'b1;
      k        = 0;
    end
    if (in_frame) begin
      samp[k] = tx_out;
      k++;
      if (k == 10 * N) begin
        in_frame = 1'b0;
        shape_ok = (samp[0] == 1'b0) && (samp[9*N] == 1'b1);
        for (int i = 0; i < 10; i++)
          for (int j = 0; j < N; j++)
            if (samp[i*N+j] != samp[i*N]) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) dec_byte[i] = samp[(i+1)*N + N/2];
        check("frame_shape", shape_ok, 1);
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_data: got %0d, expected no frame", dec_byte);
        end else begin
          check("frame_data", dec_byte, sbq.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t        = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 1000) fail_now("send_timeout");
    @(negedge CLK);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < maxc) begin
      @(negedge CLK);
      t++;
    end
    if (t >= maxc) fail_now("wait_idle");
    repeat (3) @(negedge CLK);
  endtask

  logic s2[1041];
  logic b2[1041];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t;
    int mism;
    int lows;
    int run;
    logic [7:0] exp2;
    logic [7:0] got2;

    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    check("reset_tx_out", tx_out, 1);
    check("reset_level", fifo_level, 0);

    send(8'h55);
    wait_idle(500);

    for (int b = 1; b <= 5; b++) send(8'(b));
    check("burst_level_full", fifo_level, 4);
    check("burst_ready_low", tx_ready, 0);
    send(8'h06);
    wait_idle(2000);

    send(8'h10);
    send(8'h20);
    send(8'h30);
    t = 0;
    while (edge_n + 1 != frame_end && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) fail_now("pushpop_align");
    check("pushpop_level_before", fifo_level, 2);
    tx_data  = 8'h40;
    tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    check("pushpop_level_after", fifo_level, 2);
    check("pushpop_next_start", tx_out, 0);
    wait_idle(2000);

    send(8'hA5);
    send(8'h11);
    send(8'h22);
    t = 0;
    while (!((edge_n < frame_end) && ((edge_n - cur_start) / N == 4)) && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) fail_now("reset_align");
    check("midframe_level", fifo_level, 2);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    check("rst_tx_out", tx_out, 1);
    check("rst_level", fifo_level, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    lows = 0;
    repeat (30 * N) begin
      @(negedge CLK);
      if (tx_out == 1'b0) lows++;
    end
    check("no_frame_after_reset", lows, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge CLK);
      send(8'($urandom_range(0, 255)));
    end
    wait_idle(3000);
    check("scoreboard_empty", sbq.size(), 0);

    exp2     = 8'hC3;
    d2_data  = exp2;
    d2_valid = 1'b1;
    @(negedge CLK);
    d2_valid = 1'b0;
    check("d104_level_after_accept", d2_level, 1);
    for (int i = 0; i < 1041; i++) begin
      @(negedge CLK);
      s2[i] = d2_out;
      b2[i] = d2_busy;
    end
    mism = 0;
    for (int i = 0; i < 1040; i++) begin
      int b;
      logic e;
      b = i / N2;
      e = (b == 0) ? 1'b0 : (b <= 8) ? exp2[b-1] : 1'b1;
      if (s2[i] != e) mism++;
    end
    check("d104_pattern", mism, 0);
    run = 0;
    while (run < 1041 && s2[run] == 1'b0) run++;
    check("d104_start_len", run, N2);
    for (int i = 0; i < 8; i++) got2[i] = s2[(i+1)*N2 + N2/2];
    check("d104_decoded", got2, 8'hC3);
    check("d104_busy_last_stop", b2[1039], 1);
    check("d104_busy_after", b2[1040], 0);
    check("d104_idle_line", s2[1040], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
